// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, constants and sizing helper
// for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_e;

  // ceil(bin_w * log10(2)); 30103/100000 sits just above log10(2),
  // and bin_w*log10(2) is never an exact integer for bin_w >= 1.
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell,
// adds 3 to a BCD nibble greater than 4.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q
);

  // add-3 correction, no carry out of the nibble
  always_comb begin
    q = d;
    if (d > 4'd4) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter
// with valid/ready handshakes and leading-zero decode.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = bcd_digits(BIN_W)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIB_W*DIGITS-1:0]      bcd,
  output logic [$clog2(DIGITS+1)-1:0]  nz_digits,
  output logic [DIGITS-1:0]            blank_mask
);

  localparam int BCD_W = NIB_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int NZ_W  = $clog2(DIGITS + 1);

  if (BIN_W < 1) begin : g_bad_w
    $error("bin2bcd_seq: BIN_W must be >= 1");
  end
  if (DIGITS < bcd_digits(BIN_W)) begin : g_bad_d
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  b2b_state_e       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sr_q[BIN_W+NIB_W*g +: NIB_W]),
      .q (adj[NIB_W*g +: NIB_W])
    );
  end

  // state, shift register and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {adj, sr_q[BIN_W-1:0]} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd = sr_q[SR_W-1 -: BCD_W];

  // significant-digit count and leading-zero mask
  always_comb begin
    nz_digits  = NZ_W'(1);
    blank_mask = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[NIB_W*i +: NIB_W] != '0) nz_digits = NZ_W'(i + 1);
    end
    for (int i = 0; i < DIGITS; i++) begin
      blank_mask[i] = (NZ_W'(i) >= nz_digits);
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq at
// BIN_W=8 and BIN_W=16/DIGITS=5.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv_a, ir_a, ov_a, or_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic [1:0]  nz_a;
  logic [2:0]  bm_a;

  logic        iv_b, ir_b, ov_b, or_b;
  logic [15:0] bin_b;
  logic [19:0] bcd_b;
  logic [2:0]  nz_b;
  logic [4:0]  bm_b;

  bin2bcd_seq #(.BIN_W(8)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv_a),
    .in_ready   (ir_a),
    .bin        (bin_a),
    .out_valid  (ov_a),
    .out_ready  (or_a),
    .bcd        (bcd_a),
    .nz_digits  (nz_a),
    .blank_mask (bm_a)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv_b),
    .in_ready   (ir_b),
    .bin        (bin_b),
    .out_valid  (ov_b),
    .out_ready  (or_b),
    .bcd        (bcd_b),
    .nz_digits  (nz_b),
    .blank_mask (bm_b)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] v, output int lat);
    iv_a = 1'b1;
    bin_a = v;
    step();
    iv_a = 1'b0;
    lat = 1;
    while (!ov_a && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_b(input logic [15:0] v, output int lat);
    iv_b = 1'b1;
    bin_b = v;
    step();
    iv_b = 1'b0;
    lat = 1;
    while (!ov_b && lat < 60) begin
      step();
      lat++;
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    iv_a = 1'b0; or_a = 1'b0; bin_a = '0;
    iv_b = 1'b0; or_b = 1'b0; bin_b = '0;
    step();
    step();
    rst_n = 1'b1;

    chk("rst_in_ready", 32'(ir_a), 32'd1);
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'h000);
    chk("rst_nz", 32'(nz_a), 32'd1);
    chk("rst_mask", 32'(bm_a), 32'b110);

    // value 0: full latency, blanked leading digits
    run_a(8'd0, lat);
    chk("z_lat", 32'(lat), 32'd9);
    chk("z_bcd", 32'(bcd_a), 32'h000);
    chk("z_nz", 32'(nz_a), 32'd1);
    chk("z_mask", 32'(bm_a), 32'b110);
    or_a = 1'b1;
    step();
    chk("z_back_idle", 32'(ir_a), 32'd1);
    chk("z_ov_drop", 32'(ov_a), 32'd0);

    // value 255 with out_ready high
    run_a(8'd255, lat);
    chk("ff_lat", 32'(lat), 32'd9);
    chk("ff_bcd", 32'(bcd_a), 32'h255);
    chk("ff_nz", 32'(nz_a), 32'd3);
    chk("ff_mask", 32'(bm_a), 32'b000);
    step();
    chk("ff_ready10", 32'(ir_a), 32'd1);
    chk("ff_hold", 32'(bcd_a), 32'h255);
    or_a = 1'b0;

    // value 7 under backpressure, stray input ignored
    run_a(8'd7, lat);
    chk("s_lat", 32'(lat), 32'd9);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        iv_a = 1'b1;
        bin_a = 8'd99;
      end
      chk("s_hold_bcd", 32'(bcd_a), 32'h007);
      chk("s_hold_v", {bm_a, nz_a, ov_a, ir_a}, {3'b110, 2'd1, 1'b1, 1'b0});
      step();
    end
    iv_a = 1'b0;
    or_a = 1'b1;
    step();
    chk("s_release", 32'(ir_a), 32'd1);
    chk("s_after_bcd", 32'(bcd_a), 32'h007);
    or_a = 1'b0;

    // reset mid-conversion, then fresh word
    iv_a = 1'b1;
    bin_a = 8'd200;
    step();
    iv_a = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_ready", 32'(ir_a), 32'd1);
    chk("mr_ov", 32'(ov_a), 32'd0);
    chk("mr_bcd", 32'(bcd_a), 32'h000);
    chk("mr_nz", 32'(nz_a), 32'd1);
    chk("mr_mask", 32'(bm_a), 32'b110);
    run_a(8'd42, lat);
    chk("mr_lat", 32'(lat), 32'd9);
    chk("mr_bcd42", 32'(bcd_a), 32'h042);
    chk("mr_nz42", 32'(nz_a), 32'd2);
    chk("mr_mask42", 32'(bm_a), 32'b100);
    or_a = 1'b1;
    step();

    // 16-bit instance
    or_b = 1'b0;
    run_b(16'd65535, lat);
    chk("w_lat", 32'(lat), 32'd17);
    chk("w_bcd", 32'(bcd_b), 32'h65535);
    chk("w_nz", 32'(nz_b), 32'd5);
    chk("w_mask", 32'(bm_b), 32'b00000);
    or_b = 1'b1;
    step();
    chk("w_ready", 32'(ir_b), 32'd1);
    or_b = 1'b0;
    run_b(16'd1000, lat);
    chk("k_lat", 32'(lat), 32'd17);
    chk("k_bcd", 32'(bcd_b), 32'h01000);
    chk("k_nz", 32'(nz_b), 32'd4);
    chk("k_mask", 32'(bm_b), 32'b10000);
    or_b = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
